// File: rtl/spinner_scheduler_pkg.sv
// Shared constants and helpers for the spinner scheduler: quadrature Gray codes,
// Gray stepping functions, saturation limits and the FSM state type.
package spinner_scheduler_pkg;

  localparam int POS_W = 12;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_e;

  // Positive travel walks 11->01->00->10->11.
  function automatic logic [1:0] grayNext(input logic [1:0] q);
    case (q)
      Q11:     return Q01;
      Q01:     return Q00;
      Q00:     return Q10;
      default: return Q11;
    endcase
  endfunction

  // Negative travel walks 11->10->00->01->11.
  function automatic logic [1:0] grayPrev(input logic [1:0] q);
    case (q)
      Q11:     return Q10;
      Q10:     return Q00;
      Q00:     return Q01;
      default: return Q11;
    endcase
  endfunction

  // Symmetric clamp magnitude for a w-bit signed accumulator.
  function automatic int satMax(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/spinner_scheduler_quad_stepper.sv
// Quadrature phase generator: advances the {A,B} Gray code one step per enable,
// forward when dir=1 and backward when dir=0.
module quad_stepper
  import spinner_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  output logic [1:0] quad
);

  logic [1:0] quad_q;
  logic [1:0] quad_d;

  always_comb begin
    quad_d = quad_q;
    if (en) begin
      quad_d = dir ? grayNext(quad_q) : grayPrev(quad_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quad_q <= Q11;
    end else begin
      quad_q <= quad_d;
    end
  end

  assign quad = quad_q;

endmodule

// File: rtl/spinner_scheduler.sv
// Spinner scheduler: merges mouse deltas and keyboard auto-spin into a saturating
// signed accumulator and drains it one quadrature step per step_ce.
module spinner_scheduler #(
  parameter int POS_W      = spinner_scheduler_pkg::POS_W,
  parameter int KEY_PERIOD = 48000,
  parameter int KEY_SLOW   = 4,
  parameter int KEY_FAST   = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_ce,
  input  logic                    mouse_valid,
  input  logic signed [7:0]       mouse_dx,
  output logic                    mouse_ready,
  input  logic                    key_left,
  input  logic                    key_right,
  input  logic                    key_fast,
  output logic [1:0]              quad,
  output logic                    busy,
  output logic signed [POS_W-1:0] position
);

  import spinner_scheduler_pkg::*;

  // Two guard bits so pos +/- step + injection never wraps before the clamp.
  localparam int SW = POS_W + 2;
  localparam int TW = (KEY_PERIOD > 1) ? $clog2(KEY_PERIOD) : 1;
  localparam logic signed [SW-1:0] SAT_HI = SW'(satMax(POS_W));
  localparam logic signed [SW-1:0] SAT_LO = -SAT_HI;

  state_e                 state_q;
  state_e                 state_d;
  logic signed [POS_W-1:0] pos_q;
  logic signed [POS_W-1:0] pos_d;
  logic [TW-1:0]          keyTimer_q;
  logic [TW-1:0]          keyTimer_d;

  logic                   keyInj;
  logic                   mouseAccept;
  logic                   stepEn;
  logic                   stepDir;
  logic signed [SW-1:0]   keyMag;
  logic signed [SW-1:0]   inj;
  logic signed [SW-1:0]   stepVal;
  logic signed [SW-1:0]   sum;

  // Key timer only runs while exactly one direction key is held.
  always_comb begin
    keyInj     = 1'b0;
    keyTimer_d = '0;
    if (key_left ^ key_right) begin
      if (keyTimer_q == TW'(KEY_PERIOD - 1)) begin
        keyInj = 1'b1;
      end else begin
        keyTimer_d = keyTimer_q + TW'(1);
      end
    end
  end

  assign mouse_ready = ~reset & ~keyInj;
  assign mouseAccept = mouse_valid & mouse_ready;

  always_comb begin
    keyMag = key_fast ? SW'(KEY_FAST) : SW'(KEY_SLOW);
    inj    = '0;
    if (keyInj) begin
      inj = key_right ? keyMag : -keyMag;
    end else if (mouseAccept) begin
      inj = SW'(mouse_dx);
    end
  end

  always_comb begin
    stepVal = '0;
    if (stepEn) begin
      stepVal = stepDir ? SW'(1) : {SW{1'b1}};
    end
    sum = SW'(pos_q) - stepVal + inj;
    if (sum > SAT_HI) begin
      pos_d = SAT_HI[POS_W-1:0];
    end else if (sum < SAT_LO) begin
      pos_d = SAT_LO[POS_W-1:0];
    end else begin
      pos_d = sum[POS_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q      <= '0;
      keyTimer_q <= '0;
    end else begin
      pos_q      <= pos_d;
      keyTimer_q <= keyTimer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // State tracks whether the accumulator will hold any residual motion.
  always_comb begin
    state_d = (pos_d != '0) ? STEP : IDLE;
  end

  always_comb begin
    busy    = (state_q == STEP);
    stepEn  = (state_q == STEP) & step_ce;
    stepDir = ~pos_q[POS_W-1];
  end

  quad_stepper u_quad_stepper (
    .clk   (clk),
    .reset (reset),
    .en    (stepEn),
    .dir   (stepDir),
    .quad  (quad)
  );

  assign position = pos_q;

endmodule

// File: tb/tb_spinner_scheduler.sv
// Directed self-checking bench for spinner_scheduler (POS_W=8, KEY_PERIOD=10).
module tb_spinner_scheduler;

  localparam int POS_W      = 8;
  localparam int KEY_PERIOD = 10;
  localparam int KEY_SLOW   = 4;
  localparam int KEY_FAST   = 9;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    step_ce = 1'b0;
  logic                    mouse_valid = 1'b0;
  logic signed [7:0]       mouse_dx = '0;
  logic                    mouse_ready;
  logic                    key_left = 1'b0;
  logic                    key_right = 1'b0;
  logic                    key_fast = 1'b0;
  logic [1:0]              quad;
  logic                    busy;
  logic signed [POS_W-1:0] position;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spinner_scheduler #(
    .POS_W      (POS_W),
    .KEY_PERIOD (KEY_PERIOD),
    .KEY_SLOW   (KEY_SLOW),
    .KEY_FAST   (KEY_FAST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .step_ce     (step_ce),
    .mouse_valid (mouse_valid),
    .mouse_dx    (mouse_dx),
    .mouse_ready (mouse_ready),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_fast    (key_fast),
    .quad        (quad),
    .busy        (busy),
    .position    (position)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic sce, input logic mv, input logic signed [7:0] dx,
                               input logic kl, input logic kr, input logic kf);
    step_ce     = sce;
    mouse_valid = mv;
    mouse_dx    = dx;
    key_left    = kl;
    key_right   = kr;
    key_fast    = kf;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    int qA[3];
    int pA[3];
    int bA[3];
    int qD[3];
    int pD[3];
    qA = '{1, 0, 2};
    pA = '{2, 1, 0};
    bA = '{1, 1, 0};
    qD = '{0, 1, 3};
    pD = '{-2, -1, 0};

    $display("[TB] start");
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("reset_pos", position, 0);
    checkOutput("reset_quad", quad, 3);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ready", mouse_ready, 0);
    applyStimulus(1'b0, 1'b1, 8'sd5, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_ready_valid", mouse_ready, 0);
    tick(1);
    checkOutput("reset_ignores_mouse", position, 0);

    // Release reset with step_ce high while idle: nothing may move.
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    checkOutput("release_ready", mouse_ready, 1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_step_quad", quad, 3);
    checkOutput("idle_step_pos", position, 0);

    // +3 drained by step_ce every 4 cycles.
    applyStimulus(1'b0, 1'b1, 8'sd3, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    checkOutput("plus3_pos", position, 3);
    checkOutput("plus3_busy", busy, 1);
    checkOutput("plus3_quad", quad, 3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("drain%0d_quad", i), quad, qA[i]);
      checkOutput($sformatf("drain%0d_pos", i), position, pA[i]);
      checkOutput($sformatf("drain%0d_busy", i), busy, bA[i]);
      tick(3);
    end
    applyStimulus(1'b1, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_hold_quad", quad, 2);

    // Opposite-sign injection nets out and reverses the quad walk.
    applyStimulus(1'b0, 1'b1, 8'sd2, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("rev_set_pos", position, 2);
    applyStimulus(1'b0, 1'b1, -8'sd5, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    checkOutput("rev_net_pos", position, -3);
    checkOutput("rev_net_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("rev%0d_quad", i), quad, qD[i]);
      checkOutput($sformatf("rev%0d_pos", i), position, pD[i]);
    end
    checkOutput("rev_done_busy", busy, 0);

    // Step and crossing injection in the same cycle; new sign governs next step.
    applyStimulus(1'b0, 1'b1, 8'sd1, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, -8'sd4, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    checkOutput("cross_pos", position, -4);
    checkOutput("cross_quad", quad, 1);
    applyStimulus(1'b1, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    checkOutput("cross_next_quad", quad, 3);
    checkOutput("cross_next_pos", position, -3);
    applyStimulus(1'b0, 1'b1, 8'sd3, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    checkOutput("cross_clear_busy", busy, 0);

    // Saturation at both ends.
    applyStimulus(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("sat_neg1", position, -127);
    tick(1);
    checkOutput("sat_neg2", position, -127);
    applyStimulus(1'b0, 1'b1, 8'sd127, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("sat_up1", position, 0);
    tick(1);
    checkOutput("sat_up2", position, 127);
    tick(1);
    checkOutput("sat_pos", position, 127);
    applyStimulus(1'b0, 1'b1, -8'sd127, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_clear", position, 0);

    // key_right fast: injection in the 10th cycle, mouse packet held then taken.
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b1, 1'b1);
    tick(9);
    applyStimulus(1'b0, 1'b1, 8'sd5, 1'b0, 1'b1, 1'b1);
    checkOutput("key_inj_ready", mouse_ready, 0);
    checkOutput("key_inj_pos_before", position, 0);
    tick(1);
    checkOutput("key_inj_pos", position, 9);
    checkOutput("key_after_ready", mouse_ready, 1);
    applyStimulus(1'b0, 1'b1, 8'sd5, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    checkOutput("held_packet_pos", position, 14);

    // key_left slow.
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b1, 1'b0, 1'b0);
    tick(9);
    checkOutput("key_left_pre", position, 14);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    checkOutput("key_left_slow", position, 10);

    // Both keys hold the timer at zero, discarding partial progress.
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b1, 1'b1);
    tick(5);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b1, 1'b1, 1'b1);
    tick(3 * KEY_PERIOD);
    checkOutput("both_keys_pos", position, 10);
    checkOutput("both_keys_ready", mouse_ready, 1);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b1, 1'b1);
    tick(9);
    checkOutput("timer_restart_pre", position, 10);
    checkOutput("timer_restart_ready", mouse_ready, 0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    checkOutput("timer_restart_pos", position, 19);

    // Reach +40 with quad=00, then reset mid-operation.
    applyStimulus(1'b0, 1'b1, 8'sd23, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("pre_reset_load", position, 42);
    applyStimulus(1'b1, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_pos", position, 40);
    checkOutput("pre_reset_quad", quad, 0);
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_ready", mouse_ready, 0);
    tick(1);
    checkOutput("reset_mid_pos", position, 0);
    checkOutput("reset_mid_quad", quad, 3);
    checkOutput("reset_mid_busy", busy, 0);
    checkOutput("reset_mid_ready_hold", mouse_ready, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, -8'sd2, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_ready", mouse_ready, 1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_accept", position, -2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
